// File: rtl/alu_status_stage.sv
// -----------------------------------------------------------------------------
// alu_status_stage
//
// Sits directly behind the 32-bit ALU. Evaluates the instruction's ARM-style
// condition code against the architectural NZCV flags, commits new flags when
// the instruction asks for it, and buffers {result, rd, write-enable} in a
// 2-entry skid FIFO toward register-file writeback.
//
// Handshake: a transfer happens on a rising CLK edge where valid & ready are
// both high. A producer holding valid must keep its payload stable until the
// transfer; ready never depends combinationally on valid (both IN_READY and
// OUT_VALID are decoded from the registered occupancy count).
//
// Optional build macro: STICKY_OVF_EN adds CLR_STICKY / STICKY_V, a sticky
// overflow bit set by any flag-committing instruction that produced V=1.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   IN_VALID / IN_READY   upstream handshake
//   RESULT_IN, NZVC_IN    ALU result and its {N,Z,V,C} flags
//   SET_FLAGS, COND, RD_IN  instruction S bit, condition code, destination
//   OUT_VALID / OUT_READY writeback handshake
//   RESULT_OUT, RD_OUT, WE_OUT  head entry (WE_OUT = condition passed)
//   FLAGS_OUT             architectural {N,Z,V,C}
//   CLR_STICKY, STICKY_V  (STICKY_OVF_EN only) sticky overflow clear/status
// -----------------------------------------------------------------------------
module alu_status_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] RESULT_IN,
    input  logic [3:0]       NZVC_IN,
    input  logic             SET_FLAGS,
    input  logic [3:0]       COND,
    input  logic [RA_W-1:0]  RD_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT_OUT,
    output logic [RA_W-1:0]  RD_OUT,
    output logic             WE_OUT,
`ifdef STICKY_OVF_EN
    input  logic             CLR_STICKY,
    output logic             STICKY_V,
`endif
    output logic [3:0]       FLAGS_OUT
);

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_res [2];
    logic [RA_W-1:0]  r_rd  [2];
    logic             r_we  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [3:0]       r_flags;

    logic w_accept;
    logic w_pop;
    logic w_pass;

    // Condition check against {N,Z,V,C}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        logic res;
        n   = f[3];
        z   = f[2];
        v   = f[1];
        cy  = f[0];
        res = 1'b0;
        case (c)
            4'h0: res = z;
            4'h1: res = !z;
            4'h2: res = cy;
            4'h3: res = !cy;
            4'h4: res = n;
            4'h5: res = !n;
            4'h6: res = v;
            4'h7: res = !v;
            4'h8: res = cy & !z;
            4'h9: res = !cy | z;
            4'hA: res = (n == v);
            4'hB: res = (n != v);
            4'hC: res = !z & (n == v);
            4'hD: res = z | (n != v);
            4'hE: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign IN_READY  = (r_count != 2'd2);
    assign OUT_VALID = (r_count != 2'd0);
    assign w_accept  = IN_VALID & IN_READY;
    assign w_pop     = OUT_VALID & OUT_READY;
    // Evaluated against the committed flags, which already reflect every
    // earlier accepted instruction, so dependent ops issue back-to-back.
    assign w_pass    = cond_pass(COND, r_flags);

    assign RESULT_OUT = r_res[r_rd_ptr];
    assign RD_OUT     = r_rd[r_rd_ptr];
    assign WE_OUT     = r_we[r_rd_ptr];
    assign FLAGS_OUT  = r_flags;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                r_res[i] <= '0;
                r_rd[i]  <= '0;
                r_we[i]  <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_flags  <= 4'b0000;
        end else begin
            if (w_accept) begin
                // Failed-condition entries are still queued (WE=0) so
                // writeback order matches issue order.
                r_res[r_wr_ptr] <= RESULT_IN;
                r_rd[r_wr_ptr]  <= RD_IN;
                r_we[r_wr_ptr]  <= w_pass;
                r_wr_ptr        <= ~r_wr_ptr;
                if (w_pass && SET_FLAGS) begin
                    r_flags <= NZVC_IN;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STICKY_OVF_EN
    logic r_sticky;

    // Set has priority over clear when both happen in one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sticky <= 1'b0;
        end else if (w_accept && w_pass && SET_FLAGS && NZVC_IN[1]) begin
            r_sticky <= 1'b1;
        end else if (CLR_STICKY) begin
            r_sticky <= 1'b0;
        end
    end

    assign STICKY_V = r_sticky;
`endif

endmodule

// File: tb/tb_alu_status_stage.sv
module tb_alu_status_stage;

  localparam int WIDTH = 32;
  localparam int RA_W  = 4;

  logic             CLK;
  logic             RST_N;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] RESULT_IN;
  logic [3:0]       NZVC_IN;
  logic             SET_FLAGS;
  logic [3:0]       COND;
  logic [RA_W-1:0]  RD_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT_OUT;
  logic [RA_W-1:0]  RD_OUT;
  logic             WE_OUT;
  logic [3:0]       FLAGS_OUT;
`ifdef STICKY_OVF_EN
  logic             CLR_STICKY;
  logic             STICKY_V;
`endif

  int total = 0;
  int bad   = 0;

  alu_status_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .RESULT_IN  (RESULT_IN),
    .NZVC_IN    (NZVC_IN),
    .SET_FLAGS  (SET_FLAGS),
    .COND       (COND),
    .RD_IN      (RD_IN),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .RESULT_OUT (RESULT_OUT),
    .RD_OUT     (RD_OUT),
    .WE_OUT     (WE_OUT),
`ifdef STICKY_OVF_EN
    .CLR_STICKY (CLR_STICKY),
    .STICKY_V   (STICKY_V),
`endif
    .FLAGS_OUT  (FLAGS_OUT)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] nzvc,
                       input logic sf, input logic [3:0] c, input logic [3:0] rd);
    IN_VALID  = v;
    RESULT_IN = res;
    NZVC_IN   = nzvc;
    SET_FLAGS = sf;
    COND      = c;
    RD_IN     = rd;
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] pass_mask;

  initial begin
    RST_N     = 1'b0;
    OUT_READY = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
`ifdef STICKY_OVF_EN
    CLR_STICKY = 1'b0;
`endif
    #12;
    // reset state
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("rst_flags", {28'b0, FLAGS_OUT}, 32'h0);
    chk("rst_result", RESULT_OUT, 32'h0);
    chk("rst_rd", {28'b0, RD_OUT}, 32'h0);
    chk("rst_we", {31'b0, WE_OUT}, 32'd0);
`ifdef STICKY_OVF_EN
    chk("rst_sticky", {31'b0, STICKY_V}, 32'd0);
`endif
    #5;
    RST_N = 1'b1;

    // single op
    OUT_READY = 1'b1;
    drive(1'b1, 32'h5, 4'b0000, 1'b1, 4'hE, 4'd3);
    tick();
    chk("single_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("single_result", RESULT_OUT, 32'h5);
    chk("single_rd", {28'b0, RD_OUT}, 32'd3);
    chk("single_we", {31'b0, WE_OUT}, 32'd1);
    chk("single_flags", {28'b0, FLAGS_OUT}, 32'h0);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("single_drained", {31'b0, OUT_VALID}, 32'd0);

    // back-to-back dependency: EQ sees the Z just committed
    drive(1'b1, 32'h6, 4'b0100, 1'b1, 4'hE, 4'd1);
    tick();
    chk("b2b_flags", {28'b0, FLAGS_OUT}, 32'h4);
    chk("b2b_first_res", RESULT_OUT, 32'h6);
    drive(1'b1, 32'h7, 4'b0000, 1'b0, 4'h0, 4'd2);
    tick();
    chk("b2b_eq_res", RESULT_OUT, 32'h7);
    chk("b2b_eq_we", {31'b0, WE_OUT}, 32'd1);
    chk("b2b_eq_rd", {28'b0, RD_OUT}, 32'd2);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    // NE fails against Z=1 and must not disturb flags even with S set
    drive(1'b1, 32'h6, 4'b0100, 1'b1, 4'hE, 4'd1);
    tick();
    drive(1'b1, 32'h8, 4'b0000, 1'b1, 4'h1, 4'd2);
    tick();
    chk("b2b_ne_res", RESULT_OUT, 32'h8);
    chk("b2b_ne_we", {31'b0, WE_OUT}, 32'd0);
    chk("b2b_ne_flags", {28'b0, FLAGS_OUT}, 32'h4);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();

    // failed VS with S set leaves flags alone but still enqueues
    drive(1'b1, 32'h9, 4'b0000, 1'b1, 4'hE, 4'd4);
    tick();
    chk("vs_pre_flags", {28'b0, FLAGS_OUT}, 32'h0);
    drive(1'b1, 32'hA, 4'b1010, 1'b1, 4'h6, 4'd5);
    tick();
    chk("vs_flags", {28'b0, FLAGS_OUT}, 32'h0);
    chk("vs_we", {31'b0, WE_OUT}, 32'd0);
    chk("vs_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("vs_res", RESULT_OUT, 32'hA);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();

    // all 16 conditions, streamed one per cycle, for two flag patterns
    // flags N=1 Z=0 V=0 C=1
    pass_mask = 16'h6996;
    drive(1'b1, 32'h0, 4'b1001, 1'b1, 4'hE, 4'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h100 + i, 4'b0000, 1'b0, i[3:0], i[3:0]);
      tick();
      chk($sformatf("cond_a_we_%0d", i), {31'b0, WE_OUT}, {31'b0, pass_mask[i]});
      chk($sformatf("cond_a_res_%0d", i), RESULT_OUT, 32'h100 + i);
      chk($sformatf("cond_a_rdy_%0d", i), {31'b0, IN_READY}, 32'd1);
    end
    chk("cond_a_flags", {28'b0, FLAGS_OUT}, 32'h9);
    // flags N=0 Z=1 V=1 C=0
    pass_mask = 16'h6A69;
    drive(1'b1, 32'h0, 4'b0110, 1'b1, 4'hE, 4'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h200 + i, 4'b0000, 1'b0, i[3:0], i[3:0]);
      tick();
      chk($sformatf("cond_b_we_%0d", i), {31'b0, WE_OUT}, {31'b0, pass_mask[i]});
      chk($sformatf("cond_b_rd_%0d", i), {28'b0, RD_OUT}, i);
    end
    chk("cond_b_flags", {28'b0, FLAGS_OUT}, 32'h6);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("cond_drained", {31'b0, OUT_VALID}, 32'd0);

    // backpressure: third op must wait, order preserved
    OUT_READY = 1'b0;
    drive(1'b1, 32'h1, 4'h0, 1'b0, 4'hE, 4'd0);
    tick();
    chk("bp_rdy_1", {31'b0, IN_READY}, 32'd1);
    drive(1'b1, 32'h2, 4'h0, 1'b0, 4'hE, 4'd0);
    tick();
    chk("bp_rdy_2", {31'b0, IN_READY}, 32'd0);
    drive(1'b1, 32'h3, 4'h0, 1'b0, 4'hE, 4'd0);
    tick();
    chk("bp_held_rdy", {31'b0, IN_READY}, 32'd0);
    chk("bp_held_res", RESULT_OUT, 32'h1);
    OUT_READY = 1'b1;
    tick();
    chk("bp_out_2", RESULT_OUT, 32'h2);
    chk("bp_rdy_3", {31'b0, IN_READY}, 32'd1);
    tick();
    chk("bp_out_3", RESULT_OUT, 32'h3);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("bp_drained", {31'b0, OUT_VALID}, 32'd0);

    // reset with two entries buffered
    OUT_READY = 1'b0;
    drive(1'b1, 32'h11, 4'b1111, 1'b1, 4'hE, 4'd1);
    tick();
    drive(1'b1, 32'h12, 4'b1111, 1'b1, 4'hE, 4'd2);
    tick();
    chk("mid_full", {31'b0, IN_READY}, 32'd0);
    chk("mid_flags", {28'b0, FLAGS_OUT}, 32'hF);
`ifdef STICKY_OVF_EN
    chk("mid_sticky", {31'b0, STICKY_V}, 32'd1);
`endif
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("mid_rst_flags", {28'b0, FLAGS_OUT}, 32'h0);
    chk("mid_rst_ready", {31'b0, IN_READY}, 32'd1);
`ifdef STICKY_OVF_EN
    chk("mid_rst_sticky", {31'b0, STICKY_V}, 32'd0);
`endif
    #1;
    RST_N = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, OUT_VALID}, 32'd0);

`ifdef STICKY_OVF_EN
    OUT_READY = 1'b1;
    drive(1'b1, 32'h21, 4'b0010, 1'b1, 4'hE, 4'd1);
    tick();
    chk("sticky_set", {31'b0, STICKY_V}, 32'd1);
    drive(1'b1, 32'h22, 4'b0000, 1'b1, 4'hE, 4'd1);
    tick();
    chk("sticky_hold", {31'b0, STICKY_V}, 32'd1);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    CLR_STICKY = 1'b1;
    tick();
    CLR_STICKY = 1'b0;
    chk("sticky_clr", {31'b0, STICKY_V}, 32'd0);
    // set beats clear in the same cycle
    drive(1'b1, 32'h23, 4'b0010, 1'b1, 4'hE, 4'd1);
    CLR_STICKY = 1'b1;
    tick();
    CLR_STICKY = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("sticky_set_wins", {31'b0, STICKY_V}, 32'd1);
    tick();
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
